alu_issue: RTL and testbench
============================

# alu_issue

Sequential issue/capture front-end for the combinational `alu`; it drives the ALU's `oc`/`a`/`b` inputs and samples its `f` output. It accepts one operation per request handshake, holds the operands stable on the ALU inputs for an opcode-dependent number of cycles, and captures the result. The result is returned on a response handshake. It sits between the instruction/control path and `alu`, giving multiply and divide a multicycle settling budget.

## Interface
- `DATA_WIDTH`, 16, operand/result width; matches `alu`.
- `MUL_CYCLES`, 2, cycles operands are held for opcode 3'b010; values <1 are treated as 1.
- `DIV_CYCLES`, 4, cycles operands are held for opcode 3'b011; values <1 are treated as 1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_oc`  in  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 not, 101 xor, 110 or, 111 and.
- `req_a`  in  DATA_WIDTH  operand a.
- `req_b`  in  DATA_WIDTH  operand b.
- `alu_oc`  out  3  registered opcode to the ALU.
- `alu_a`  out  DATA_WIDTH  registered operand a to the ALU.
- `alu_b`  out  DATA_WIDTH  registered operand b to the ALU.
- `alu_f`  in  DATA_WIDTH  ALU result.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_f`  out  DATA_WIDTH  captured result.
- `rsp_oc`  out  3  opcode that produced `rsp_f`.
- `rsp_dz`  out  1  divide-by-zero flag (see Configuration).

## Operation
- The FSM has three states: IDLE, EXEC and DONE. Reset enters IDLE.
- **IDLE:** `req_ready`=1. On `req_valid && req_ready`:
  - latch `req_oc`/`req_a`/`req_b` into `alu_oc`/`alu_a`/`alu_b`;
  - load `cnt` = L-1, where L=1 for all opcodes except mul (L=`MUL_CYCLES`) and div (L=`DIV_CYCLES`);
  - go to EXEC.
- **EXEC:** `req_ready`=0 and the `alu_*` outputs are held stable.
  - If `cnt`==0: capture `alu_f` into `rsp_f`, `alu_oc` into `rsp_oc`, update `rsp_dz`, and go to DONE.
  - Otherwise decrement `cnt`.
- **DONE:** `rsp_valid`=1. `rsp_f`/`rsp_oc`/`rsp_dz` are stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`, go to IDLE.
  - `req_ready` stays 0 in DONE. There is no overlap, so there is one bubble cycle between back-to-back operations.
- `req_*` inputs are ignored outside the IDLE handshake. `alu_f` is ignored except on the capture edge.
- Width rules: `rsp_f` is exactly `alu_f` with no extension. Mul keeps the low DATA_WIDTH bits. Div by zero yields 0 from the ALU.
- `cnt` is wide enough for max(`MUL_CYCLES`,`DIV_CYCLES`)-1.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, so `req_ready`=1;
  - `rsp_valid`=0;
  - `alu_oc`/`alu_a`/`alu_b`=0;
  - `rsp_f`=0, `rsp_oc`=0, `rsp_dz`=0;
  - `cnt`=0.
- Latency: the accept edge is E. `rsp_valid` rises after edge E+L, i.e. it is visible in the cycle following edge E+L.
  - Single-cycle ops: `rsp_valid` is high one cycle after the accept cycle.
- Throughput: one operation per L+2 cycles at best (L EXEC cycles, at least 1 DONE cycle, 1 IDLE cycle).
- `req_ready` and `rsp_valid` are decoded from registered state only, with no combinational path from `req_valid` or `rsp_ready`.
- Reset mid-operation (EXEC or DONE) aborts the transaction: no response is produced and all outputs take their reset values.
- If `rsp_ready` is held low, DONE persists indefinitely with outputs unchanged.

## Configuration
- Macro: `ALU_ISSUE_DZ_FLAG_EN`.
- **Defined:** `rsp_dz` is registered on the capture edge as (`alu_oc`==3'b011 && `alu_b`==0) and cleared on capture of any other op.
- **Undefined:** `rsp_dz` is tied to constant 0 and no flag logic is synthesized. All other behaviour is identical.

## Test plan
- Reset then idle:
  - during reset, `req_ready`=1, `rsp_valid`=0, and all data outputs are 0;
  - assert `rst` mid-EXEC of a div; `rsp_valid` never rises and the block is back in IDLE.
- add a=16'h0005, b=16'h0003 with `rsp_ready`=1:
  - `alu_*` is driven the cycle after accept;
  - `rsp_valid` rises 1 cycle after the accept cycle with `rsp_f`=16'h0008, `rsp_oc`=3'b000;
  - then `req_ready` returns to 1.
- mul a=16'h0100, b=16'h0100 with MUL_CYCLES=2: `rsp_valid` rises 2 cycles after the accept cycle with `rsp_f`=16'h0000 (low bits).
- div a=16'd100, b=16'd7 with DIV_CYCLES=4: `rsp_f`=16'd14 after 4 cycles and `rsp_dz`=0.
- div a=16'd9, b=0: `rsp_f`=0; `rsp_dz`=1 with `ALU_ISSUE_DZ_FLAG_EN` defined, 0 without.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after an xor of 16'hFF00 and 16'h0FF0.
  - `rsp_f`=16'hF0F0 stays stable and `req_ready` stays 0;
  - a `req_valid` presented meanwhile is not accepted until 1 cycle after the `rsp_ready` handshake.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: issue/capture front-end for a combinational ALU with per-opcode settling budget.
// Optional feature: define ALU_ISSUE_DZ_FLAG_EN to register a divide-by-zero flag on rsp_dz.
module alu_issue #(
    parameter int DATA_WIDTH = 16,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_oc,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic [2:0]            alu_oc,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_f,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_f,
    output logic [2:0]            rsp_oc,
    output logic                  rsp_dz
);
    localparam int ML   = MUL_CYCLES < 1 ? 1 : MUL_CYCLES;
    localparam int DL   = DIV_CYCLES < 1 ? 1 : DIV_CYCLES;
    localparam int MAXL = ML > DL ? ML : DL;
    localparam int CW   = MAXL > 1 ? $clog2(MAXL) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            alu_oc_q, alu_oc_d, rsp_oc_q, rsp_oc_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_f_q, rsp_f_d;

    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == DONE;
    assign alu_oc    = alu_oc_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_f     = rsp_f_q;
    assign rsp_oc    = rsp_oc_q;

`ifdef ALU_ISSUE_DZ_FLAG_EN
    logic dz_q, dz_d;
    assign rsp_dz = dz_q;
    // divide-by-zero flag, refreshed on every capture
    always_comb begin
        dz_d = dz_q;
        if (state_q == EXEC && cnt_q == '0) dz_d = alu_oc_q == 3'b011 && alu_b_q == '0;
    end
    // flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dz_q <= 1'b0;
        else     dz_q <= dz_d;
    end
`else
    assign rsp_dz = 1'b0;
`endif

    // next-state: accept in IDLE, count down settling cycles in EXEC, hold result in DONE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alu_oc_d = alu_oc_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        rsp_f_d  = rsp_f_q;
        rsp_oc_d = rsp_oc_q;
        case (state_q)
            IDLE: if (req_valid) begin
                alu_oc_d = req_oc;
                alu_a_d  = req_a;
                alu_b_d  = req_b;
                cnt_d    = req_oc == 3'b010 ? CW'(ML - 1) : req_oc == 3'b011 ? CW'(DL - 1) : '0;
                state_d  = EXEC;
            end
            EXEC: if (cnt_q == '0) begin
                rsp_f_d  = alu_f;
                rsp_oc_d = alu_oc_q;
                state_d  = DONE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            DONE: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            alu_oc_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            rsp_f_q  <= '0;
            rsp_oc_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_oc_q <= alu_oc_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            rsp_f_q  <= rsp_f_d;
            rsp_oc_q <= rsp_oc_d;
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue with a behavioural ALU attached.
module tb_alu_issue;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   req_oc = '0;
    logic [W-1:0] req_a = '0, req_b = '0;
    logic [2:0]   alu_oc;
    logic [W-1:0] alu_a, alu_b, alu_f;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_f;
    logic [2:0]   rsp_oc;
    logic         rsp_dz;

    alu_issue dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_oc(req_oc), .req_a(req_a), .req_b(req_b),
        .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f),
        .rsp_oc(rsp_oc), .rsp_dz(rsp_dz)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_model(input logic [2:0] oc, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = a * b;
        case (oc)
            3'b000: return a + b;
            3'b001: return a - b;
            3'b010: return p[W-1:0];
            3'b011: return b == '0 ? '0 : a / b;
            3'b100: return ~a;
            3'b101: return a ^ b;
            3'b110: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] oc);
        return oc == 3'b010 ? 2 : oc == 3'b011 ? 4 : 1;
    endfunction

    function automatic logic dz_of(input logic [2:0] oc, input logic [W-1:0] b);
`ifdef ALU_ISSUE_DZ_FLAG_EN
        return oc == 3'b011 && b == '0;
`else
        return 1'b0;
`endif
    endfunction

    // combinational ALU stand-in
    always_comb alu_f = alu_model(alu_oc, alu_a, alu_b);

    typedef struct {
        logic [W-1:0] f;
        logic [2:0]   oc;
        logic         dz;
        int           acc;
        int           lat;
    } exp_t;

    exp_t q[$];
    int   nvec = 0, nerr = 0, cyc = 0, rsp_seen_cnt = 0;
    logic seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // response monitor: compare the first cycle of each response against the scoreboard
    always @(negedge clk) begin
        if (rst || !rsp_valid) seen <= 1'b0;
        else if (!seen) begin
            exp_t e;
            seen <= 1'b1;
            rsp_seen_cnt++;
            if (q.size() == 0) check("unexpected_rsp", 32'(rsp_f), 32'hDEAD_BEEF);
            else begin
                e = q.pop_front();
                check("rsp_f", 32'(rsp_f), 32'(e.f));
                check("rsp_oc", 32'(rsp_oc), 32'(e.oc));
                check("rsp_dz", 32'(rsp_dz), 32'(e.dz));
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [2:0] oc, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        exp_t e;
        req_valid = 1'b1;
        req_oc = oc;
        req_a = a;
        req_b = b;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
        e.f = alu_model(oc, a, b);
        e.oc = oc;
        e.dz = dz_of(oc, b);
        e.acc = cyc + 1;
        e.lat = lat_of(oc);
        q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        check("alu_oc", 32'(alu_oc), 32'(oc));
        check("alu_a", 32'(alu_a), 32'(a));
        check("alu_b", 32'(alu_b), 32'(b));
        check("req_ready_exec", 32'(req_ready), 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(q.size() == 0 && req_ready), 32'd1);
    endtask

    initial begin
        int seen0;
        logic [2:0] ro;
        logic [W-1:0] ra, rb;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu", {13'd0, alu_oc, alu_a | alu_b}, 32'd0);
        check("rst_rsp", {13'd0, rsp_oc, rsp_f}, 32'd0);
        check("rst_dz", 32'(rsp_dz), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(3'b000, 16'h0005, 16'h0003);
        drain();
        check("ready_after_add", 32'(req_ready), 32'd1);
        issue(3'b010, 16'h0100, 16'h0100);
        drain();
        issue(3'b011, 16'd100, 16'd7);
        drain();
        issue(3'b011, 16'd9, 16'd0);
        drain();
        issue(3'b001, 16'h0003, 16'h0005);
        drain();
        issue(3'b100, 16'h1234, 16'h0000);
        drain();
        issue(3'b110, 16'hA000, 16'h000A);
        drain();
        for (int i = 0; i < 10; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = (i % 4 == 0) ? '0 : W'($urandom);
            issue(ro, ra, rb);
            drain();
        end

        // backpressure with a competing request
        rsp_ready = 1'b0;
        issue(3'b101, 16'hFF00, 16'h0FF0);
        repeat (2) @(negedge clk);
        req_valid = 1'b1;
        req_oc = 3'b111;
        req_a = 16'h00FF;
        req_b = 16'h0F0F;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_f", 32'(rsp_f), 32'hF0F0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_alu_oc", 32'(alu_oc), 32'd5);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_after", 32'(req_ready), 32'd1);
        check("bp_not_yet", 32'(alu_oc), 32'd5);
        issue(3'b111, 16'h00FF, 16'h0F0F);
        drain();

        // reset mid-EXEC of a divide aborts it
        issue(3'b011, 16'd50, 16'd5);
        rst = 1'b1;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_alu", {13'd0, alu_oc, alu_a | alu_b}, 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        seen0 = rsp_seen_cnt;
        repeat (8) @(negedge clk);
        check("abort_no_rsp", 32'(rsp_seen_cnt - seen0), 32'd0);
        check("abort_idle", 32'(req_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
